lora_cmd_rx: RTL

//  Bicycle-side receiver for the control frames the handlebar unit sends over the LoRa UART link.

---
 rtl/lora_cmd_rx_pkg.sv | 50 +++++
 rtl/lora_cmd_rx_uart_rx_byte.sv | 104 ++++++++++
 rtl/lora_cmd_rx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/lora_cmd_rx_pkg.sv
// Shared frame definitions for the handlebar LoRa command link.
// The handlebar transmitter builds its frames from the same constants.
package lora_cmd_rx_pkg;

    localparam logic [7:0] LORA_HDR = 8'hA5;
    localparam int FRAME_LEN = 3;

    localparam int CMD_BELL_BIT = 7;
    localparam int CMD_LED_BIT  = 6;
    localparam int CMD_RGB_BIT  = 5;
    localparam int CMD_MODE_MSB = 4;
    localparam int CMD_MODE_LSB = 2;
    localparam int CMD_RSVD_MSB = 1;
    localparam int CMD_RSVD_LSB = 0;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    // One parser state per byte position in the frame.
    typedef enum logic [$clog2(FRAME_LEN)-1:0] {
        P_WAIT_HDR,
        P_GET_CMD,
        P_GET_CHK
    } parse_state_t;

    typedef struct packed {
        logic       bell;
        logic       led;
        logic       rgb;
        logic [2:0] rgb_mode;
    } ctrl_t;

    function automatic ctrl_t cmd_to_ctrl(input logic [7:0] cmd);
        ctrl_t c;
        c.bell     = cmd[CMD_BELL_BIT];
        c.led      = cmd[CMD_LED_BIT];
        c.rgb      = cmd[CMD_RGB_BIT];
        c.rgb_mode = cmd[CMD_MODE_MSB:CMD_MODE_LSB];
        return c;
    endfunction

    function automatic logic frame_valid(input logic [7:0] cmd, input logic [7:0] chk);
        return (chk == ~cmd) && (cmd[CMD_RSVD_MSB:CMD_RSVD_LSB] == 2'b00);
    endfunction

endpackage

// File: rtl/lora_cmd_rx_uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchroniser.
// RX_IDLE | wait for falling edge   RX_START | mid-start check
// RX_DATA | 8 bits, LSB first       RX_STOP  | stop-bit check
module uart_rx_byte
    import lora_cmd_rx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_error
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

    rx_state_t  state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0] bit_idx, bit_idx_nxt;
    logic [7:0] shift, shift_nxt;
    logic       valid_nxt, ferr_nxt;
    logic       rx_meta, rx_s, rx_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_prev     <= 1'b1;
            state       <= RX_IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            byte_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            rx_meta     <= rx;
            rx_s        <= rx_meta;
            rx_prev     <= rx_s;
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            shift       <= shift_nxt;
            byte_valid  <= valid_nxt;
            frame_error <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift;
        valid_nxt   = 1'b0;
        ferr_nxt    = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rx_prev && !rx_s) begin
                    state_nxt = RX_START;
                    cnt_nxt   = CNT_W'(HALF_BIT - 1);
                end
            end
            RX_START: begin
                if (cnt == '0) begin
                    if (!rx_s) begin
                        state_nxt   = RX_DATA;
                        cnt_nxt     = CNT_W'(CLKS_PER_BIT - 1);
                        bit_idx_nxt = '0;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (cnt == '0) begin
                    shift_nxt = {rx_s, shift[7:1]};
                    cnt_nxt   = CNT_W'(CLKS_PER_BIT - 1);
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            RX_STOP: begin
                // Back to idle straight from the mid-stop sample so a
                // following start bit is never missed.
                if (cnt == '0) begin
                    valid_nxt = rx_s;
                    ferr_nxt  = !rx_s;
                    state_nxt = RX_IDLE;
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    assign data = shift;

endmodule

// File: rtl/lora_cmd_rx.sv
// LoRa command-frame receiver: parser FSM, inter-byte gap timer and held outputs.
// Optional link-loss watchdog enabled by defining LORA_LINK_TIMEOUT_EN.
module lora_cmd_rx
    import lora_cmd_rx_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int BAUD        = 9600,
    parameter int GAP_BYTES   = 4,
    parameter int TIMEOUT_CYC = 150_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       lora_rx,
    output logic       bell,
    output logic       led,
    output logic       rgb,
    output logic [2:0] rgb_mode,
    output logic       frame_ok,
    output logic       frame_err,
    output logic       link_lost
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int GAP_CYC      = GAP_BYTES * 10 * CLKS_PER_BIT;
    localparam int GAP_W        = $clog2(GAP_CYC + 1);

    logic [7:0]   rx_data;
    logic         byte_valid, rx_ferr;
    parse_state_t parse_st, parse_nxt;
    logic [7:0]   cmd_q, cmd_nxt;
    logic         ok_nxt, err_nxt;
    logic [GAP_W-1:0] gap_cnt;
    logic         in_frame, gap_expire, wd_expire;
    ctrl_t        ctrl_q;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk         (clk),
        .rst         (rst),
        .rx          (lora_rx),
        .data        (rx_data),
        .byte_valid  (byte_valid),
        .frame_error (rx_ferr)
    );

    assign in_frame   = (parse_st != P_WAIT_HDR);
    assign gap_expire = in_frame && (gap_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= GAP_W'(GAP_CYC - 1);
        end else if (byte_valid || !in_frame) begin
            gap_cnt <= GAP_W'(GAP_CYC - 1);
        end else if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            parse_st  <= P_WAIT_HDR;
            cmd_q     <= '0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            parse_st  <= parse_nxt;
            cmd_q     <= cmd_nxt;
            frame_ok  <= ok_nxt;
            frame_err <= err_nxt;
        end
    end

    // ok_nxt and err_nxt are set on disjoint branches, so the pulses never overlap.
    always_comb begin
        parse_nxt = parse_st;
        cmd_nxt   = cmd_q;
        ok_nxt    = 1'b0;
        err_nxt   = 1'b0;
        case (parse_st)
            P_WAIT_HDR: begin
                if (byte_valid && rx_data == LORA_HDR) begin
                    parse_nxt = P_GET_CMD;
                end
            end
            P_GET_CMD: begin
                if (rx_ferr || (!byte_valid && gap_expire)) begin
                    err_nxt   = 1'b1;
                    parse_nxt = P_WAIT_HDR;
                end else if (byte_valid) begin
                    cmd_nxt   = rx_data;
                    parse_nxt = P_GET_CHK;
                end
            end
            P_GET_CHK: begin
                if (rx_ferr || (!byte_valid && gap_expire)) begin
                    err_nxt   = 1'b1;
                    parse_nxt = P_WAIT_HDR;
                end else if (byte_valid) begin
                    ok_nxt    = frame_valid(cmd_q, rx_data);
                    err_nxt   = !frame_valid(cmd_q, rx_data);
                    parse_nxt = P_WAIT_HDR;
                end
            end
            default: parse_nxt = P_WAIT_HDR;
        endcase
    end

`ifdef LORA_LINK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd_cnt;
    logic            link_lost_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= WD_W'(TIMEOUT_CYC - 1);
            link_lost_q <= 1'b0;
        end else if (ok_nxt) begin
            wd_cnt      <= WD_W'(TIMEOUT_CYC - 1);
            link_lost_q <= 1'b0;
        end else if (wd_cnt == '0) begin
            link_lost_q <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt - WD_W'(1);
        end
    end

    assign wd_expire = !ok_nxt && (wd_cnt == '0);
    assign link_lost = link_lost_q;
`else
    assign wd_expire = 1'b0;
    assign link_lost = 1'b0 & (TIMEOUT_CYC != 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else if (ok_nxt) begin
            ctrl_q <= cmd_to_ctrl(cmd_q);
        end else if (wd_expire) begin
            ctrl_q <= '0;
        end
    end

    assign bell     = ctrl_q.bell;
    assign led      = ctrl_q.led;
    assign rgb      = ctrl_q.rgb;
    assign rgb_mode = ctrl_q.rgb_mode;

endmodule
